// File: rtl/writeback_stage_pkg.sv
// Shared write-back definitions: load type encodings and the hard-wired zero register.
package writeback_stage_pkg;

  typedef enum logic [2:0] {
    LOAD_W  = 3'd0,
    LOAD_H  = 3'd1,
    LOAD_HU = 3'd2,
    LOAD_B  = 3'd3,
    LOAD_BU = 3'd4
  } load_type_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// Little-endian load extraction: picks the addressed byte/halfword and sign- or zero-extends it.
module load_aligner
  import writeback_stage_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] raw_word,
  output logic [31:0] aligned
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = byte_offset[1] ? raw_word[31:16] : raw_word[15:0];

    case (byte_offset)
      2'd0:    byte_sel = raw_word[7:0];
      2'd1:    byte_sel = raw_word[15:8];
      2'd2:    byte_sel = raw_word[23:16];
      default: byte_sel = raw_word[31:24];
    endcase

    // Unknown encodings fall through to a full-word pass-through.
    case (load_type)
      LOAD_H:  aligned = {{16{half_sel[15]}}, half_sel};
      LOAD_HU: aligned = {16'h0000, half_sel};
      LOAD_B:  aligned = {{24{byte_sel[7]}}, byte_sel};
      LOAD_BU: aligned = {24'h00_0000, byte_sel};
      default: aligned = raw_word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, load alignment, write-back select and retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_SIZE = 5,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                    system_clock,
  input  logic                    system_reset_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    mem_valid,
  input  logic                    mem_reg_write,
  input  logic                    mem_mem_to_reg,
  input  logic [2:0]              mem_load_type,
  input  logic [1:0]              mem_byte_offset,
  input  logic [ADDRESS_SIZE-1:0] mem_write_address,
  input  logic [DATA_WIDTH-1:0]   mem_alu_result,
  input  logic [DATA_WIDTH-1:0]   mem_load_data,
  output logic                    write_enable,
  output logic [ADDRESS_SIZE-1:0] write_address,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [COUNT_WIDTH-1:0]  retired_count
);

  logic                    valid_q;
  logic                    reg_write_q;
  logic                    mem_to_reg_q;
  logic [2:0]              load_type_q;
  logic [1:0]              byte_offset_q;
  logic [ADDRESS_SIZE-1:0] write_address_q;
  logic [DATA_WIDTH-1:0]   alu_result_q;
  logic [DATA_WIDTH-1:0]   load_data_q;
  logic [COUNT_WIDTH-1:0]  retired_count_q;
  logic [DATA_WIDTH-1:0]   aligned_load;
  logic                    hold;
  logic                    retire;

  // Flush overrides stall, so a flushed occupant leaves the stage and is retired.
  assign hold   = stall & ~flush;
  assign retire = valid_q & ~hold;

  always_ff @(posedge system_clock) begin
    if (!system_reset_n) begin
      valid_q         <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      load_type_q     <= '0;
      byte_offset_q   <= '0;
      write_address_q <= '0;
      alu_result_q    <= '0;
      load_data_q     <= '0;
      retired_count_q <= '0;
    end else begin
      if (retire) begin
        retired_count_q <= retired_count_q + COUNT_WIDTH'(1);
      end
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        valid_q         <= mem_valid;
        reg_write_q     <= mem_reg_write;
        mem_to_reg_q    <= mem_mem_to_reg;
        load_type_q     <= mem_load_type;
        byte_offset_q   <= mem_byte_offset;
        write_address_q <= mem_write_address;
        alu_result_q    <= mem_alu_result;
        load_data_q     <= mem_load_data;
      end
    end
  end

  load_aligner u_load_aligner (
    .load_type   (load_type_q),
    .byte_offset (byte_offset_q),
    .raw_word    (load_data_q),
    .aligned     (aligned_load)
  );

  assign write_enable  = valid_q & reg_write_q & (write_address_q != ADDRESS_SIZE'(REG_ZERO));
  assign write_address = write_address_q;
  assign write_data    = mem_to_reg_q ? aligned_load : alu_result_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage using a 4-bit retired counter so wrap-around is reachable.
module tb_writeback_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          system_clock = 1'b0;
  logic          system_reset_n;
  logic          stall;
  logic          flush;
  logic          mem_valid;
  logic          mem_reg_write;
  logic          mem_mem_to_reg;
  logic [2:0]    mem_load_type;
  logic [1:0]    mem_byte_offset;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_load_data;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic [CW-1:0] retired_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 system_clock = ~system_clock;

  writeback_stage #(
    .DATA_WIDTH   (DW),
    .ADDRESS_SIZE (AW),
    .COUNT_WIDTH  (CW)
  ) dut (
    .system_clock      (system_clock),
    .system_reset_n    (system_reset_n),
    .stall             (stall),
    .flush             (flush),
    .mem_valid         (mem_valid),
    .mem_reg_write     (mem_reg_write),
    .mem_mem_to_reg    (mem_mem_to_reg),
    .mem_load_type     (mem_load_type),
    .mem_byte_offset   (mem_byte_offset),
    .mem_write_address (mem_write_address),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .write_enable      (write_enable),
    .write_address     (write_address),
    .write_data        (write_data),
    .retired_count     (retired_count)
  );

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge system_clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [1:0] off, input logic [AW-1:0] addr, input logic [DW-1:0] alu);
    mem_valid         = v;
    mem_reg_write     = rw;
    mem_mem_to_reg    = m2r;
    mem_load_type     = lt;
    mem_byte_offset   = off;
    mem_write_address = addr;
    mem_alu_result    = alu;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [CW-1:0] cnt);
    check_value({tag, ".we"},   32'(write_enable),  32'(we));
    check_value({tag, ".addr"}, 32'(write_address), 32'(addr));
    check_value({tag, ".data"}, write_data,         data);
    check_value({tag, ".cnt"},  32'(retired_count), 32'(cnt));
  endtask

  initial begin
    system_reset_n = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    mem_load_data  = 32'h80FF_7F01;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'h1111_2222);

    step();
    step();
    check_port("reset", 1'b0, 5'd0, 32'h0000_0000, 4'd0);

    system_reset_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd5, 32'h1234_5678);
    step();
    check_port("alu", 1'b1, 5'd5, 32'h1234_5678, 4'd0);

    drive(1'b1, 1'b1, 1'b1, 3'd3, 2'd3, 5'd7, 32'h0);
    step();
    check_port("lb3", 1'b1, 5'd7, 32'hFFFF_FF80, 4'd1);

    drive(1'b1, 1'b1, 1'b1, 3'd4, 2'd1, 5'd7, 32'h0);
    step();
    check_port("lbu1", 1'b1, 5'd7, 32'h0000_007F, 4'd2);

    drive(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 5'd8, 32'h0);
    step();
    check_port("lh2", 1'b1, 5'd8, 32'hFFFF_80FF, 4'd3);

    drive(1'b1, 1'b1, 1'b1, 3'd2, 2'd0, 5'd8, 32'h0);
    step();
    check_port("lhu0", 1'b1, 5'd8, 32'h0000_7F01, 4'd4);

    drive(1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 5'd9, 32'h0);
    step();
    check_port("lw", 1'b1, 5'd9, 32'h80FF_7F01, 4'd5);

    drive(1'b1, 1'b1, 1'b1, 3'd7, 2'd1, 5'd9, 32'h0);
    step();
    check_port("lundef", 1'b1, 5'd9, 32'h80FF_7F01, 4'd6);

    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd0, 32'hDEAD_BEEF);
    step();
    check_port("r0", 1'b0, 5'd0, 32'hDEAD_BEEF, 4'd7);

    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd9, 32'hCAFE_0001);
    step();
    check_port("held_insn", 1'b1, 5'd9, 32'hCAFE_0001, 4'd8);

    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd3, 32'h0000_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      check_port($sformatf("stall%0d", i), 1'b1, 5'd9, 32'hCAFE_0001, 4'd8);
    end

    flush = 1'b1;
    step();
    check_value("flush.we",  32'(write_enable),  32'd0);
    check_value("flush.cnt", 32'(retired_count), 32'd9);

    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 5'd1, 32'h0000_00AA);
    step();
    check_value("bubble.we",  32'(write_enable),  32'd0);
    check_value("bubble.cnt", 32'(retired_count), 32'd9);

    mem_valid = 1'b1;
    step();
    check_value("refill.cnt", 32'(retired_count), 32'd9);
    for (int i = 0; i < 6; i++) step();
    check_value("cnt_max", 32'(retired_count), 32'd15);
    step();
    check_value("cnt_wrap", 32'(retired_count), 32'd0);

    stall = 1'b1;
    step();
    check_value("pre_rst_stall.cnt", 32'(retired_count), 32'd0);
    system_reset_n = 1'b0;
    step();
    check_port("rst_in_stall", 1'b0, 5'd0, 32'h0000_0000, 4'd0);
    system_reset_n = 1'b1;
    stall          = 1'b0;
    mem_valid      = 1'b0;
    step();
    check_value("post_rst.cnt", 32'(retired_count), 32'd0);
    check_value("post_rst.we",  32'(write_enable),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
